// File: rtl/branch_pc_unit.sv
// EX-stage control-flow unit of the 5-stage MIPS pipeline: owns the fetch PC,
// resolves branches/jumps, flushes younger stages, halts on syscall and keeps run statistics.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_beq,
  input  logic             ex_bne,
  input  logic             ex_jmp,
  input  logic             ex_jal,
  input  logic             ex_jr,
  input  logic             ex_syscall,
  input  logic             ex_zero,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [25:0]      ex_target,
  input  logic [31:0]      ex_rs_val,
  input  logic [31:0]      ex_v0,
  input  logic             stall,
  input  logic             go,
  output logic [31:0]      pc,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] jump_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] br_taken_cnt
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] jump_q, jump_d;
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic        beq_v, bne_v, jmp_v, jal_v, jr_v, sys_v;
  logic        taken, redirect, hlt;
  logic [31:0] ex_pc_plus4, br_target, jmp_target, jr_target, target;

  // Bubbles must never redirect, halt or count, so every strobe is qualified here.
  assign beq_v = ex_valid & ex_beq;
  assign bne_v = ex_valid & ex_bne;
  assign jmp_v = ex_valid & ex_jmp;
  assign jal_v = ex_valid & ex_jal;
  assign jr_v  = ex_valid & ex_jr;
  assign sys_v = ex_valid & ex_syscall;

  assign taken    = (beq_v & ex_zero) | (bne_v & ~ex_zero);
  assign redirect = taken | jmp_v | jal_v | jr_v;
  assign hlt      = sys_v & (ex_v0 == HALT_CODE);

  assign ex_pc_plus4 = ex_pc + 32'd4;
  assign br_target   = ex_pc_plus4 + (ex_imm << 2);
  assign jmp_target  = (ex_pc_plus4 & 32'hF000_0000) | {4'b0000, ex_target, 2'b00};
  assign jr_target   = ex_rs_val & 32'hFFFF_FFFC;
  assign target      = jr_v ? jr_target : ((jmp_v | jal_v) ? jmp_target : br_target);

  assign flush = (state_q == S_RUN) & (redirect | hlt);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cycle_d     = cycle_q;
    jump_d      = jump_q;
    br_d        = br_q;
    taken_cnt_d = taken_cnt_q;
    case (state_q)
      S_RUN: begin
        cycle_d = cycle_q + CNT_ONE;
        if (jmp_v | jal_v | jr_v) jump_d = jump_q + CNT_ONE;
        if (beq_v | bne_v)        br_d = br_q + CNT_ONE;
        if (taken)                taken_cnt_d = taken_cnt_q + CNT_ONE;
        // Halt wins over redirect, and redirect wins over a load-use stall.
        if (hlt) begin
          pc_d    = ex_pc_plus4;
          state_d = S_HALT;
        end else if (redirect) begin
          pc_d = target;
        end else if (!stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      S_HALT: begin
        if (go) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      cycle_q     <= '0;
      jump_q      <= '0;
      br_q        <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cycle_q     <= cycle_d;
      jump_q      <= jump_d;
      br_q        <= br_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign pc           = pc_q;
  assign halted       = (state_q == S_HALT);
  assign cycle_cnt    = cycle_q;
  assign jump_cnt     = jump_q;
  assign br_cnt       = br_q;
  assign br_taken_cnt = taken_cnt_q;

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Consumes the decoded control-flow strobes (beq, bne, jmp, jal, jr, syscall) once they reach the EX stage of the 5-stage MIPS pipeline.
- Owns the fetch PC register and computes the next-PC and redirect target.
- Drives the flush of the younger pipeline stages.
- Implements the syscall-halt state machine and the run statistics counters shown on the board display.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of every statistics counter.
- HALT_CODE, 32'd10, $v0 value that makes a syscall halt the CPU.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX-stage slot holds a real (non-bubble) instruction.
- ex_beq  in  1  EX instruction is beq.
- ex_bne  in  1  EX instruction is bne.
- ex_jmp  in  1  EX instruction is j.
- ex_jal  in  1  EX instruction is jal.
- ex_jr  in  1  EX instruction is jr.
- ex_syscall  in  1  EX instruction is syscall.
- ex_zero  in  1  ALU equality result for the EX instruction (rs==rt).
- ex_pc  in  32  PC of the EX instruction.
- ex_imm  in  32  sign-extended 16-bit immediate of the EX instruction.
- ex_target  in  26  instr[25:0] of the EX instruction.
- ex_rs_val  in  32  forwarded rs value (jr target).
- ex_v0  in  32  forwarded $v0 value.
- stall  in  1  load-use hazard; hold PC.
- go  in  1  resume pulse from the board button (already synchronised/debounced).
- pc  out  32  current fetch address.
- flush  out  1  combinational; clear IF/ID and ID/EX at the next edge.
- halted  out  1  registered; state == HALT.
- cycle_cnt  out  CNT_W  cycles spent in RUN.
- jump_cnt  out  CNT_W  executed j/jal/jr.
- br_cnt  out  CNT_W  executed beq/bne.
- br_taken_cnt  out  CNT_W  taken beq/bne.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC, state=RUN, halted=0.
  - All counters=0.
  - flush is combinational, so it is 0 while ex_valid=0.
- Qualified strobes: every ex_* strobe is ANDed with ex_valid. Bubbles never redirect, halt, or count.
- taken = (beq & ex_zero) | (bne & ~ex_zero).
- redirect = taken | jmp | jal | jr.
- hlt = syscall & (ex_v0 == HALT_CODE).
- Target selection, priority jr > jmp/jal > branch:
  - jr: {ex_rs_val[31:2], 2'b00}; low bits are forced to zero.
  - j/jal: {(ex_pc+4)[31:28], ex_target, 2'b00}.
  - branch: ex_pc + 4 + (ex_imm << 2), 32-bit modulo, wrap ignored.
- flush = state==RUN & (redirect | hlt).
- State RUN, evaluated per edge in this order:
  - hlt: pc <= ex_pc+4 (resume address), state <= HALT.
  - else redirect: pc <= target.
  - else stall: pc holds.
  - else: pc <= pc+4, wrapping at 2^32.
  - Redirect overrides stall on the same cycle.
- A syscall with ex_v0 != HALT_CODE behaves as a no-op: no flush, no count.
- State HALT:
  - pc, all counters and flush are frozen; flush=0.
  - All ex_* inputs and stall are ignored.
  - go=1 at an edge: state <= RUN; fetching resumes from the held pc next cycle.
- go while in RUN: ignored.
- Counters, RUN state only:
  - cycle_cnt +1 every RUN cycle, including stall cycles and the halting cycle.
  - jump_cnt +1 per qualified j/jal/jr.
  - br_cnt +1 per qualified beq/bne.
  - br_taken_cnt +1 when taken.
  - All counters wrap modulo 2^CNT_W and never saturate.
- Latency:
  - Redirect target is visible on pc one edge after the EX cycle.
  - halted rises one edge after the halting syscall is in EX.
- Reset mid-HALT or mid-stall: immediate return to the reset values.

Test Plan:
- Reset, then 4 free cycles with no strobes -> pc sequence 0,4,8,C,10; cycle_cnt=4; flush=0 throughout.
- ex_valid=1, ex_beq=1, ex_zero=1, ex_pc=0x40, ex_imm=0xFFFFFFFE -> flush=1 that cycle; next pc=0x3C; br_cnt=1, br_taken_cnt=1. Repeat with ex_zero=0 -> no flush; pc=prev+4; br_cnt=2, br_taken_cnt=1.
- jr with ex_rs_val=0x1237 while stall=1 -> redirect wins; pc=0x1234; jump_cnt+1. jal with ex_pc=0x9000_0010, ex_target=0x0000100 -> pc=0x9000_0400.
- Strobes with ex_valid=0 (beq, ex_zero=1) -> no flush, no count, pc increments.
- syscall, ex_v0=10, ex_pc=0x80 -> flush=1; next cycle halted=1, pc=0x84; 5 HALT cycles keep pc and cycle_cnt frozen while jr strobes are ignored; go pulse -> RUN, next pc=0x88. syscall with ex_v0=1 -> no halt, no flush.
- Preload counters near 2^CNT_W-1 (CNT_W=4 build) -> cycle_cnt wraps 15->0. Assert rst_n=0 during HALT -> asynchronous return to pc=RESET_PC, halted=0.
